// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the multiply issue controller: state encodings,
// datapath width and the default operand hold time.
package mul_issue_ctrl_pkg;

    localparam int DATA_W          = 8;
    localparam int DEFAULT_LATENCY = 3;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/mul_issue_ctrl_multiplier.sv
// 8-bit combinational array multiplier: rows of gated, shifted copies of the
// multiplicand are accumulated; only the low DATA_W bits of the product are kept.
module multiplier
    import mul_issue_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] p
);

    logic [DATA_W-1:0] acc;

    // Sum one partial-product row per multiplier bit, truncated to DATA_W bits.
    always_comb begin
        acc = '0;
        for (int i = 0; i < DATA_W; i++) begin
            acc = acc + ((a << i) & {DATA_W{b[i]}});
        end
    end

    assign p = acc;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Multiply issue controller: latches operands on START, holds them at the
// array multiplier for LATENCY clocks, then captures the product and pulses DONE.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no operation in flight, waiting for START
//   WAIT   | operands held at the multiplier, counter running (BUSY=1)
//   FINISH | product captured into RESULT this cycle (DONE=1); START
//          | here issues the next operation with no idle bubble
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int WIDTH   = DATA_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] OPERAND1,
    input  logic [WIDTH-1:0] OPERAND2,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    // Counter starts at LATENCY-1 so the capture lands exactly LATENCY edges
    // after the accepting edge (LATENCY=1 loads 0 and captures on the next edge).
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] product;
    logic             accept;

    multiplier u_mult (
        .a (op1_q),
        .b (op2_q),
        .p (product)
    );

    // Next-state, counter, operand and result update logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        result_d = result_q;
        accept   = START & ((state_q == ST_IDLE) | (state_q == ST_FINISH));

        case (state_q)
            ST_IDLE, ST_FINISH: begin
                state_d = accept ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    result_d = product;
                    state_d  = ST_FINISH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Operand registers only move on an accepted START, so mid-operation
        // changes on the input ports never reach the multiplier.
        if (accept) begin
            op1_d = OPERAND1;
            op2_d = OPERAND2;
            cnt_d = CNT_LOAD;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            result_q <= result_d;
        end
    end

    assign BUSY   = (state_q == ST_WAIT);
    assign DONE   = (state_q == ST_FINISH);
    assign RESULT = result_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: one instance with LATENCY=3 and one with LATENCY=1,
// checked against a timestamp-based model of issue/capture behaviour.
module tb_mul_issue_ctrl;

    localparam int LAT0 = 3;
    localparam int LAT1 = 1;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [1:0] start_s;
    logic [7:0] op1_s [2];
    logic [7:0] op2_s [2];
    logic [1:0] busy_s;
    logic [1:0] done_s;
    logic [7:0] result_s [2];

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    int         lat_of [2] = '{LAT0, LAT1};
    bit         m_valid [2];
    int         m_issue [2];
    logic [7:0] m_pend [2];
    logic [7:0] m_res [2];
    bit         exp_busy [2];
    bit         exp_done [2];

    mul_issue_ctrl #(.LATENCY(LAT0), .WIDTH(8)) dut0 (
        .CLK(CLK), .RESET(RESET), .START(start_s[0]),
        .OPERAND1(op1_s[0]), .OPERAND2(op2_s[0]),
        .BUSY(busy_s[0]), .DONE(done_s[0]), .RESULT(result_s[0])
    );

    mul_issue_ctrl #(.LATENCY(LAT1), .WIDTH(8)) dut1 (
        .CLK(CLK), .RESET(RESET), .START(start_s[1]),
        .OPERAND1(op1_s[1]), .OPERAND2(op2_s[1]),
        .BUSY(busy_s[1]), .DONE(done_s[1]), .RESULT(result_s[1])
    );

    always #5 CLK = ~CLK;

    // Model: an operation issued at edge k is in flight for edges k..k+L-1,
    // completes at edge k+L, and a new START is taken only after edge k+L.
    function automatic void model_edge();
        for (int i = 0; i < 2; i++) begin
            if (RESET) begin
                m_valid[i]  = 1'b0;
                m_res[i]    = 8'h00;
                exp_busy[i] = 1'b0;
                exp_done[i] = 1'b0;
            end else begin
                if (m_valid[i] && edge_n == m_issue[i] + lat_of[i])
                    m_res[i] = m_pend[i];
                if (start_s[i] && (!m_valid[i] || edge_n > m_issue[i] + lat_of[i])) begin
                    m_valid[i] = 1'b1;
                    m_issue[i] = edge_n;
                    m_pend[i]  = 8'((int'(op1_s[i]) * int'(op2_s[i])) % 256);
                end
                exp_busy[i] = m_valid[i] && edge_n >= m_issue[i] && edge_n < m_issue[i] + lat_of[i];
                exp_done[i] = m_valid[i] && edge_n == m_issue[i] + lat_of[i];
            end
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_edge();
        edge_n++;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({busy_s[i], done_s[i], result_s[i]} !== 10'h000) begin
                errors++;
                $display("FAIL reset_out inst%0d got busy=%b done=%b result=%02h exp 0/0/00",
                         i, busy_s[i], done_s[i], result_s[i]);
            end
        end
        start_s  = 2'b11;
        op1_s[0] = 8'd3; op2_s[0] = 8'd5;
        op1_s[1] = 8'd4; op2_s[1] = 8'd6;
        repeat (2) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (busy_s[i] !== 1'b0 || done_s[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL start_in_reset inst%0d got busy=%b done=%b exp 0/0",
                             i, busy_s[i], done_s[i]);
                end
            end
        end
        RESET = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy_s[i] !== 1'b1) begin
                errors++;
                $display("FAIL first_start inst%0d got busy=%b exp 1", i, busy_s[i]);
            end
        end
        start_s = 2'b00;
        repeat (4) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (busy_s[i] !== exp_busy[i] || done_s[i] !== exp_done[i] || result_s[i] !== m_res[i]) begin
                    errors++;
                    $display("FAIL model_reset inst%0d edge %0d got %b/%b/%02h exp %b/%b/%02h", i, edge_n,
                             busy_s[i], done_s[i], result_s[i], exp_busy[i], exp_done[i], m_res[i]);
                end
            end
        end
    endtask

    task automatic test_basic();
        logic eb, ed;
        start_s[0] = 1'b1; op1_s[0] = 8'd5; op2_s[0] = 8'd7;
        for (int c = 0; c < 5; c++) begin
            tick();
            start_s[0] = 1'b0;
            eb = (c <= 2);
            ed = (c == 3);
            checks++;
            if (busy_s[0] !== eb || done_s[0] !== ed || (ed && result_s[0] !== 8'h23)) begin
                errors++;
                $display("FAIL basic_5x7 cycle %0d got busy=%b done=%b result=%02h exp %b/%b/23",
                         c + 1, busy_s[0], done_s[0], result_s[0], eb, ed);
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (busy_s[i] !== exp_busy[i] || done_s[i] !== exp_done[i] || result_s[i] !== m_res[i]) begin
                    errors++;
                    $display("FAIL model_basic inst%0d edge %0d got %b/%b/%02h exp %b/%b/%02h", i, edge_n,
                             busy_s[i], done_s[i], result_s[i], exp_busy[i], exp_done[i], m_res[i]);
                end
            end
        end
    endtask

    task automatic test_boundary();
        logic [7:0] a_t [3] = '{8'hFF, 8'h10, 8'h00};
        logic [7:0] b_t [3] = '{8'hFF, 8'h10, 8'hAB};
        logic [7:0] r_t [3] = '{8'h01, 8'h00, 8'h00};
        for (int t = 0; t < 3; t++) begin
            start_s[0] = 1'b1; op1_s[0] = a_t[t]; op2_s[0] = b_t[t];
            for (int c = 0; c < 5; c++) begin
                tick();
                start_s[0] = 1'b0;
                if (c == 3) begin
                    checks++;
                    if (done_s[0] !== 1'b1 || result_s[0] !== r_t[t]) begin
                        errors++;
                        $display("FAIL boundary_%02hx%02h got done=%b result=%02h exp 1/%02h",
                                 a_t[t], b_t[t], done_s[0], result_s[0], r_t[t]);
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (busy_s[i] !== exp_busy[i] || done_s[i] !== exp_done[i] || result_s[i] !== m_res[i]) begin
                        errors++;
                        $display("FAIL model_boundary inst%0d edge %0d got %b/%b/%02h exp %b/%b/%02h", i, edge_n,
                                 busy_s[i], done_s[i], result_s[i], exp_busy[i], exp_done[i], m_res[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        start_s[0] = 1'b1; op1_s[0] = 8'd5; op2_s[0] = 8'd7;
        for (int c = 0; c < 9; c++) begin
            tick();
            if (c == 0) begin op1_s[0] = 8'd3; op2_s[0] = 8'd4; end
            if (c == 4) start_s[0] = 1'b0;
            if (c == 3) begin
                checks++;
                if (done_s[0] !== 1'b1 || result_s[0] !== 8'h23) begin
                    errors++;
                    $display("FAIL b2b_ignored got done=%b result=%02h exp 1/23", done_s[0], result_s[0]);
                end
            end
            if (c == 4) begin
                checks++;
                if (busy_s[0] !== 1'b1 || done_s[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_reissue got busy=%b done=%b exp 1/0", busy_s[0], done_s[0]);
                end
            end
            if (c == 7) begin
                checks++;
                if (done_s[0] !== 1'b1 || result_s[0] !== 8'h0C) begin
                    errors++;
                    $display("FAIL b2b_second got done=%b result=%02h exp 1/0c", done_s[0], result_s[0]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (busy_s[i] !== exp_busy[i] || done_s[i] !== exp_done[i] || result_s[i] !== m_res[i]) begin
                    errors++;
                    $display("FAIL model_b2b inst%0d edge %0d got %b/%b/%02h exp %b/%b/%02h", i, edge_n,
                             busy_s[i], done_s[i], result_s[i], exp_busy[i], exp_done[i], m_res[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        start_s[0] = 1'b1; op1_s[0] = 8'd5; op2_s[0] = 8'd7;
        tick();
        start_s[0] = 1'b0;
        tick();
        RESET = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({busy_s[i], done_s[i], result_s[i]} !== 10'h000) begin
                errors++;
                $display("FAIL reset_async inst%0d got busy=%b done=%b result=%02h exp 0/0/00",
                         i, busy_s[i], done_s[i], result_s[i]);
            end
        end
        tick();
        RESET = 1'b0;
        repeat (6) begin
            tick();
            checks++;
            if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || result_s[0] !== 8'h00) begin
                errors++;
                $display("FAIL reset_abandon got busy=%b done=%b result=%02h exp 0/0/00",
                         busy_s[0], done_s[0], result_s[0]);
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (busy_s[i] !== exp_busy[i] || done_s[i] !== exp_done[i] || result_s[i] !== m_res[i]) begin
                    errors++;
                    $display("FAIL model_resetmid inst%0d edge %0d got %b/%b/%02h exp %b/%b/%02h", i, edge_n,
                             busy_s[i], done_s[i], result_s[i], exp_busy[i], exp_done[i], m_res[i]);
                end
            end
        end
    endtask

    task automatic test_latency1();
        start_s[1] = 1'b1; op1_s[1] = 8'd9; op2_s[1] = 8'd9;
        for (int c = 0; c < 3; c++) begin
            tick();
            start_s[1] = 1'b0;
            checks++;
            if (busy_s[1] !== (c == 0) || done_s[1] !== (c == 1) || (c == 1 && result_s[1] !== 8'h51)) begin
                errors++;
                $display("FAIL lat1_9x9 cycle %0d got busy=%b done=%b result=%02h exp %b/%b/51",
                         c + 1, busy_s[1], done_s[1], result_s[1], c == 0, c == 1);
            end
        end
    endtask

    task automatic test_operand_change();
        start_s[0] = 1'b1; op1_s[0] = 8'd2; op2_s[0] = 8'd3;
        for (int c = 0; c < 5; c++) begin
            tick();
            start_s[0] = 1'b0;
            op1_s[0] = 8'($urandom);
            op2_s[0] = 8'($urandom);
            if (c == 3) begin
                checks++;
                if (done_s[0] !== 1'b1 || result_s[0] !== 8'h06) begin
                    errors++;
                    $display("FAIL operand_hold got done=%b result=%02h exp 1/06", done_s[0], result_s[0]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            RESET   = ($urandom_range(0, 39) == 0);
            start_s = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                op1_s[i] = 8'($urandom);
                op2_s[i] = 8'($urandom);
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (busy_s[i] !== exp_busy[i] || done_s[i] !== exp_done[i] || result_s[i] !== m_res[i]) begin
                    errors++;
                    $display("FAIL model_random inst%0d edge %0d got %b/%b/%02h exp %b/%b/%02h", i, edge_n,
                             busy_s[i], done_s[i], result_s[i], exp_busy[i], exp_done[i], m_res[i]);
                end
            end
        end
        RESET   = 1'b0;
        start_s = 2'b00;
    endtask

    initial begin
        RESET   = 1'b1;
        start_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            op1_s[i]    = 8'h00;
            op2_s[i]    = 8'h00;
            m_valid[i]  = 1'b0;
            m_issue[i]  = 0;
            m_pend[i]   = 8'h00;
            m_res[i]    = 8'h00;
            exp_busy[i] = 1'b0;
            exp_done[i] = 1'b0;
        end
        @(negedge CLK);
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_latency1();
        test_operand_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
